// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and small helpers for the LCD text engine.
// HD44780 command bytes and DDRAM row bases live here so every block agrees on them.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_SPACE     = 8'h20;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_INIT,
        ST_SCAN,
        ST_ADDR,
        ST_CHAR,
        ST_WAIT,
        ST_SETTLE
    } state_e;

    function automatic logic [6:0] row_base(input int row);
        case (row)
            0:       return 7'h00;
            1:       return 7'h40;
            2:       return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// Character buffer with per-entry dirty bits, host write port, space-fill sweep and scan read port.
// A dirty set always beats a same-cycle dirty clear so a racing write is never lost.
module lcd_char_buf
    import lcd_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          clr_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_dirty_o,
    input  logic          dclr_en_i,
    input  logic [AW-1:0] dclr_addr_i,
    output logic          wr_rdy_o,
    output logic          any_dirty_o
);

    logic [7:0]    mem_q [N];
    logic [N-1:0]  dirty_q, dirty_d;
    logic          sweep_q, sweep_d;
    logic [AW-1:0] sptr_q, sptr_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          addr_ok;

    assign addr_ok = ({1'b0, wr_addr_i} < (AW+1)'(N));

    always_comb begin
        sweep_d = sweep_q;
        sptr_d  = sptr_q;
        we      = 1'b0;
        waddr   = wr_addr_i;
        wdata   = wr_data_i;
        if (clr_i) begin
            sweep_d = 1'b1;
            sptr_d  = '0;
        end else if (sweep_q) begin
            we    = 1'b1;
            waddr = sptr_q;
            wdata = LCD_SPACE;
            if (sptr_q == AW'(N - 1)) begin
                sweep_d = 1'b0;
            end else begin
                sptr_d = sptr_q + AW'(1);
            end
        end else if (wr_en_i && addr_ok) begin
            we = 1'b1;
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (dclr_en_i) begin
            dirty_d[dclr_addr_i] = 1'b0;
        end
        if (we) begin
            dirty_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sweep_q <= 1'b1;
            sptr_q  <= '0;
            dirty_q <= '0;
        end else begin
            sweep_q <= sweep_d;
            sptr_q  <= sptr_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_data_o   = mem_q[rd_addr_i];
    assign rd_dirty_o  = dirty_q[rd_addr_i];
    assign wr_rdy_o    = !sweep_q;
    assign any_dirty_o = |dirty_q;

endmodule

// File: rtl/lcd_controller.sv
// Byte-level HD44780 bus sequencer: latches a byte on start, pulses EN, reports done.
// done is a one-cycle strobe six cycles after start is first seen high.
module lcd_controller
    import lcd_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    output logic       oDONE,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    logic       busy_q;
    logic [2:0] cnt_q;
    logic [7:0] data_q;
    logic       rs_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            busy_q <= 1'b0;
            cnt_q  <= 3'd0;
        end else if (!busy_q) begin
            busy_q <= iSTART;
            cnt_q  <= 3'd0;
        end else if (cnt_q == 3'd5) begin
            busy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!busy_q && iSTART) begin
            data_q <= iDATA;
            rs_q   <= iRS;
        end
    end

    // Setup cycle, three EN-high cycles, one hold cycle, then done.
    assign LCD_EN   = busy_q && (cnt_q >= 3'd1) && (cnt_q <= 3'd3);
    assign oDONE    = busy_q && (cnt_q == 3'd5);
    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: rtl/lcd_text_engine.sv
// ROWS x COLS text buffer front-end for an HD44780 panel: runs the init sequence,
// then streams only dirty characters, skipping the DDRAM address command when the cursor already matches.
module lcd_text_engine
    import lcd_pkg::*;
#(
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int SETTLE_CYCLES = 262142,
    parameter int DLY_W         = 18,
    localparam int N            = ROWS * COLS,
    localparam int AW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iWR_EN,
    input  logic [AW-1:0] iWR_ADDR,
    input  logic [7:0]    iWR_DATA,
    input  logic          iCLR,
    output logic          oWR_RDY,
    output logic          oINIT_DONE,
    output logic          oBUSY,
    output logic [7:0]    LCD_DATA,
    output logic          LCD_RW,
    output logic          LCD_EN,
    output logic          LCD_RS
);

    localparam logic [DLY_W-1:0] SETTLE_LAST = DLY_W'(SETTLE_CYCLES - 1);

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [AW-1:0] scan_ptr_q, scan_ptr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] cursor_q, cursor_d;
    logic          cursor_vld_q, cursor_vld_d;
    logic          init_done_q, init_done_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic [7:0]    chr_q, chr_d;

    logic [7:0]    buf_rd_data;
    logic          buf_rd_dirty;
    logic          buf_any_dirty;
    logic          dclr_en;
    logic          ctl_start;
    logic          ctl_done;
    logic [6:0]    ddram_addr;
    logic          last_col;

    function automatic logic [6:0] ddram_of(input logic [AW-1:0] idx);
        int r;
        int c;
        r = int'(idx) / COLS;
        c = int'(idx) % COLS;
        return row_base(r) + 7'(c);
    endfunction

    assign ddram_addr = ddram_of(idx_q);
    assign last_col   = ((int'(idx_q) % COLS) == (COLS - 1));

    lcd_char_buf #(
        .N  (N),
        .AW (AW)
    ) u_buf (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .wr_en_i     (iWR_EN),
        .wr_addr_i   (iWR_ADDR),
        .wr_data_i   (iWR_DATA),
        .clr_i       (iCLR),
        .rd_addr_i   (scan_ptr_q),
        .rd_data_o   (buf_rd_data),
        .rd_dirty_o  (buf_rd_dirty),
        .dclr_en_i   (dclr_en),
        .dclr_addr_i (scan_ptr_q),
        .wr_rdy_o    (oWR_RDY),
        .any_dirty_o (buf_any_dirty)
    );

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        init_idx_d   = init_idx_q;
        scan_ptr_d   = scan_ptr_q;
        idx_d        = idx_q;
        cursor_d     = cursor_q;
        cursor_vld_d = cursor_vld_q;
        init_done_d  = init_done_q;
        byte_d       = byte_q;
        rs_d         = rs_q;
        chr_d        = chr_q;
        dclr_en      = 1'b0;
        case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DLY_W'(1);
                end
            end
            ST_INIT: begin
                byte_d     = init_byte(init_idx_q);
                rs_d       = 1'b0;
                state_d    = ST_WAIT;
                init_idx_d = init_idx_q + 2'd1;
                if (init_idx_q == 2'd3) begin
                    ret_d        = ST_SCAN;
                    cursor_vld_d = 1'b0;
                end else begin
                    ret_d = ST_INIT;
                end
            end
            ST_SCAN: begin
                // Dirty bit is dropped at latch time; a later host write re-marks the entry.
                if (buf_rd_dirty) begin
                    idx_d   = scan_ptr_q;
                    chr_d   = buf_rd_data;
                    dclr_en = 1'b1;
                    state_d = ST_ADDR;
                end
                scan_ptr_d = (scan_ptr_q == AW'(N - 1)) ? '0 : scan_ptr_q + AW'(1);
            end
            ST_ADDR: begin
                if (cursor_vld_q && (cursor_q == idx_q)) begin
                    state_d = ST_CHAR;
                end else begin
                    byte_d  = LCD_SET_DDRAM | {1'b0, ddram_addr};
                    rs_d    = 1'b0;
                    ret_d   = ST_CHAR;
                    state_d = ST_WAIT;
                end
            end
            ST_CHAR: begin
                byte_d       = chr_q;
                rs_d         = 1'b1;
                ret_d        = ST_SCAN;
                state_d      = ST_WAIT;
                cursor_d     = idx_q + AW'(1);
                cursor_vld_d = !last_col;
            end
            ST_WAIT: begin
                if (ctl_done) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ret_q;
                    if (ret_q == ST_SCAN) begin
                        init_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DLY_W'(1);
                end
            end
            default: state_d = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= ST_RST_HOLD;
            ret_q        <= ST_INIT;
            cnt_q        <= '0;
            init_idx_q   <= 2'd0;
            scan_ptr_q   <= '0;
            cursor_q     <= '0;
            cursor_vld_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            init_idx_q   <= init_idx_d;
            scan_ptr_q   <= scan_ptr_d;
            cursor_q     <= cursor_d;
            cursor_vld_q <= cursor_vld_d;
            init_done_q  <= init_done_d;
        end
    end

    always_ff @(posedge iCLK) begin
        idx_q  <= idx_d;
        byte_q <= byte_d;
        rs_q   <= rs_d;
        chr_q  <= chr_d;
    end

    assign ctl_start  = (state_q == ST_WAIT);
    assign oINIT_DONE = init_done_q;
    assign oBUSY      = (state_q != ST_SCAN) | buf_any_dirty;

    lcd_controller u_ctl (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iSTART   (ctl_start),
        .iDATA    (byte_q),
        .iRS      (rs_q),
        .oDONE    (ctl_done),
        .LCD_DATA (LCD_DATA),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN),
        .LCD_RS   (LCD_RS)
    );

endmodule
